filter2d_tx: RTL and testbench

//  Frame-stream transmitter: reads one stored image from a synchronous-read memory and emits it as the

---
 rtl/filter2d_pkg.sv | 17 +
 rtl/filter2d_tx_agen.sv | 44 ++++
 rtl/filter2d_tx.sv | 107 ++++++++++
 tb/tb_filter2d_tx.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter2d_pkg.sv
// Shared constants and FSM encoding for the filter2d family (tx, buf, op).
package filter2d_pkg;

  localparam int DEF_IMG_W = 256;
  localparam int DEF_IMG_H = 256;
  localparam int DEF_AW    = 16;
  localparam int DEF_DW    = 8;
  localparam int GAP_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/filter2d_tx_agen.sv
// Raster-order address generator: col/row counters plus a linear address kept in step with them.
module filter2d_tx_agen #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          clear,
  input  logic          advance,
  output logic [AW-1:0] addr,
  output logic          last_col,
  output logic          last_pix
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_row;

  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));
  assign last_pix = last_col && last_row;

  // Raster order makes row*IMG_W+col a plain increment, so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (n_reset || clear) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (advance) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
      addr <= last_pix ? '0 : addr + AW'(1);
    end
  end

endmodule

// File: rtl/filter2d_tx.sv
// Frame transmitter: reads a stored image in raster order and emits it as a strobed pixel stream.
module filter2d_tx
  import filter2d_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic [GAP_W-1:0] i_gap,
  input  logic             i_pause,
  output logic             busy,
  output logic             done,
  output logic             mem_rd,
  output logic [AW-1:0]    rd_addr,
  input  logic [DW-1:0]    rd_data,
  output logic             o_strb,
  output logic [DW-1:0]    o_data,
  output logic             o_sof,
  output logic             o_eol
);

  state_e           state, state_nx;
  logic [GAP_W-1:0] gap_q, gap_cnt;
  logic             drain_cnt;
  logic             accept, rd_go, last_col, last_pix;
  logic             v1, sof1, eol1;

  assign accept = (state == IDLE) && start;
  // Combinational so that a falling i_pause resumes reading in that same cycle.
  assign rd_go  = (state == RUN) && (gap_cnt == '0) && !i_pause;
  assign mem_rd = rd_go;
  assign busy   = (state == RUN) || (state == DRAIN);
  assign done   = (state == DONE);

  filter2d_tx_agen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .AW    (AW)
  ) u_agen (
    .clk      (clk),
    .n_reset  (n_reset),
    .clear    (accept),
    .advance  (rd_go),
    .addr     (rd_addr),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (rd_go && last_pix) state_nx = DRAIN;
      DRAIN:   if (drain_cnt) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (n_reset) begin
      state     <= IDLE;
      gap_q     <= '0;
      gap_cnt   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nx;
      drain_cnt <= (state == DRAIN) && !drain_cnt;
      if (accept) begin
        gap_q   <= i_gap;
        gap_cnt <= '0;
      end else if (rd_go) begin
        gap_cnt <= gap_q;
      end else if ((state == RUN) && !i_pause && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  // Flags ride alongside the read so they line up with the returning pixel two cycles later.
  always_ff @(posedge clk) begin
    if (n_reset) begin
      v1     <= 1'b0;
      sof1   <= 1'b0;
      eol1   <= 1'b0;
      o_strb <= 1'b0;
      o_sof  <= 1'b0;
      o_eol  <= 1'b0;
      o_data <= '0;
    end else begin
      v1     <= rd_go;
      sof1   <= rd_go && (rd_addr == '0);
      eol1   <= rd_go && last_col;
      o_strb <= v1;
      o_sof  <= sof1;
      o_eol  <= eol1;
      if (v1) o_data <= rd_data;
    end
  end

endmodule

// File: tb/tb_filter2d_tx.sv
// Bench for filter2d_tx on a 4x4 image with mem[a] = a + 8'h10 behind a synchronous-read memory.
module tb_filter2d_tx;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       n_reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] i_gap = '0;
  logic       i_pause = 1'b0;
  logic       busy, done, mem_rd, o_strb, o_sof, o_eol;
  logic [3:0] rd_addr;
  logic [7:0] rd_data = '0;
  logic [7:0] o_data;
  logic [7:0] mem [NPIX];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_cnt = 0;

  int         strb_cyc [$];
  logic [7:0] strb_dat [$];
  logic       strb_sof [$];
  logic       strb_eol [$];
  int         done_cyc [$];

  filter2d_tx #(.IMG_W(W), .IMG_H(H), .AW(4), .DW(8)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (start),
    .i_gap   (i_gap),
    .i_pause (i_pause),
    .busy    (busy),
    .done    (done),
    .mem_rd  (mem_rd),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .o_strb  (o_strb),
    .o_data  (o_data),
    .o_sof   (o_sof),
    .o_eol   (o_eol)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (mem_rd) rd_data <= mem[rd_addr];

  always @(negedge clk) begin
    if (mem_rd) rd_cnt++;
    if (o_strb) begin
      strb_cyc.push_back(cyc);
      strb_dat.push_back(o_data);
      strb_sof.push_back(o_sof);
      strb_eol.push_back(o_eol);
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic clear_log();
    strb_cyc.delete();
    strb_dat.delete();
    strb_sof.delete();
    strb_eol.delete();
    done_cyc.delete();
  endtask

  task automatic start_frame(input logic [3:0] g, output int sc);
    @(posedge clk); #1;
    i_gap = g;
    start = 1'b1;
    sc    = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    i_gap = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (done_cyc.size() > 0) break;
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (done_cyc.size() == 0) begin
      n_err++;
      $display("FAIL %s done_timeout: got no done within %0d cycles, required one", name, budget);
    end
  endtask

  // Expected frame: pixel i carries 8'h10+i, sof on i==0, eol on the last column of each row.
  task automatic check_frame(input string name, input int sc, input int g, input bit timed);
    int n;
    logic [9:0] act, exp;
    n = strb_dat.size();
    n_vec++;
    if (n != NPIX) begin
      n_err++;
      $display("FAIL %s strobe_count: got %0d, required %0d", name, n, NPIX);
    end
    for (int i = 0; i < n && i < NPIX; i++) begin
      act = {strb_dat[i], strb_sof[i], strb_eol[i]};
      exp = {8'(8'h10 + i), (i == 0), ((i % W) == W - 1)};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s pixel%0d {data,sof,eol}: got %h/%b/%b, required %h/%b/%b", name, i,
                 act[9:2], act[1], act[0], exp[9:2], exp[1], exp[0]);
      end
    end
    if (timed && n > 0) begin
      n_vec++;
      if (strb_cyc[0] != sc + 3) begin
        n_err++;
        $display("FAIL %s first_latency: got %0d cycles, required 3", name, strb_cyc[0] - sc);
      end
      for (int i = 1; i < n; i++) begin
        n_vec++;
        if (strb_cyc[i] - strb_cyc[i-1] != g + 1) begin
          n_err++;
          $display("FAIL %s spacing%0d: got %0d cycles, required %0d", name, i,
                   strb_cyc[i] - strb_cyc[i-1], g + 1);
        end
      end
    end
    n_vec++;
    if (n == 0 || done_cyc.size() != 1 || done_cyc[0] != strb_cyc[n-1] + 1) begin
      n_err++;
      $display("FAIL %s done_timing: got %0d done pulses (first at %0d), required 1 at %0d", name,
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1,
               (n > 0) ? strb_cyc[n-1] + 1 : -1);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_after: got %b, required 0", name, busy);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_vec++;
    if ({busy, done, mem_rd, o_strb, o_sof, o_eol, rd_addr, o_data} !== '0) begin
      n_err++;
      $display("FAIL %s outputs: got busy=%b done=%b mem_rd=%b strb=%b sof=%b eol=%b addr=%h data=%h, required all 0",
               name, busy, done, mem_rd, o_strb, o_sof, o_eol, rd_addr, o_data);
    end
  endtask

  task automatic test_reset();
    int base;
    n_reset = 1'b1;
    start   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_hold");
    start   = 1'b0;
    n_reset = 1'b0;
    base    = rd_cnt;
    clear_log();
    repeat (6) @(posedge clk);
    #1;
    check_outputs_zero("reset_after");
    n_vec++;
    if (rd_cnt != base || strb_dat.size() != 0) begin
      n_err++;
      $display("FAIL reset_start_ignored: got %0d reads %0d strobes, required 0 and 0",
               rd_cnt - base, strb_dat.size());
    end
  endtask

  task automatic test_gap(input logic [3:0] g, input string name);
    int sc;
    clear_log();
    start_frame(g, sc);
    wait_done(name, 400);
    check_frame(name, sc, int'(g), 1'b1);
  endtask

  task automatic test_pause();
    int sc, base, p0, rd_at_pause, in_win, late;
    clear_log();
    base = rd_cnt;
    start_frame(4'd0, sc);
    for (int k = 0; k < 50; k++) begin
      if (rd_cnt - base >= 6) break;
      @(posedge clk); #1;
    end
    i_pause     = 1'b1;
    p0          = cyc;
    rd_at_pause = rd_cnt;
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (rd_cnt != rd_at_pause) begin
      n_err++;
      $display("FAIL pause_reads: got %0d reads while paused, required 0", rd_cnt - rd_at_pause);
    end
    i_pause = 1'b0;
    wait_done("pause", 200);
    in_win = 0;
    late   = 0;
    foreach (strb_cyc[i]) begin
      if (strb_cyc[i] >= p0 && strb_cyc[i] <= p0 + 4) in_win++;
      if (strb_cyc[i] >= p0 + 2 && strb_cyc[i] <= p0 + 4) late++;
    end
    n_vec++;
    if (in_win > 2 || late != 0) begin
      n_err++;
      $display("FAIL pause_strobes: got %0d in window (%0d late), required <=2 and 0 late", in_win, late);
    end
    check_frame("pause", sc, 0, 1'b0);
  endtask

  task automatic test_random_pause();
    int sc;
    logic [3:0] g;
    for (int f = 0; f < 3; f++) begin
      clear_log();
      g = 4'($urandom_range(0, 3));
      start_frame(g, sc);
      for (int k = 0; k < 600; k++) begin
        @(posedge clk); #1;
        i_pause = ($urandom_range(0, 99) < 30);
        if (done_cyc.size() > 0) break;
      end
      i_pause = 1'b0;
      wait_done("rand_pause", 50);
      check_frame("rand_pause", sc, int'(g), 1'b0);
    end
  endtask

  task automatic test_start_ignored();
    int sc;
    clear_log();
    start_frame(4'd1, sc);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (strb_dat.size() >= 5) break;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (strb_dat.size() >= NPIX) break;
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL restart_done_cycle: got done=%b, required 1", done);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check_frame("restart_ignored", sc, 1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int n, sc;
    clear_log();
    start_frame(4'd0, sc);
    n = 0;
    for (int k = 0; k < 100 && n < 7; k++) begin
      @(negedge clk);
      if (o_strb) n++;
    end
    n_reset = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("reset_mid");
    n_reset = 1'b0;
    clear_log();
    repeat (10) @(posedge clk);
    #1;
    n_vec++;
    if (strb_dat.size() != 0 || done_cyc.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid_abort: got %0d strobes %0d done, required 0 and 0",
               strb_dat.size(), done_cyc.size());
    end
    clear_log();
    start_frame(4'd0, sc);
    wait_done("reset_restart", 100);
    check_frame("reset_restart", sc, 0, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < NPIX; a++) mem[a] = 8'(a + 8'h10);
    test_reset();
    test_gap(4'd0, "gap0");
    test_gap(4'd2, "gap2");
    test_gap(4'($urandom_range(1, 7)), "gap_rand");
    test_pause();
    test_random_pause();
    test_start_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
